// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: one shared period counter (edge- or center-aligned)
// with double-buffered period/duty/mode applied only at period boundaries.
module pwm_multichannel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 21
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      mode,
  input  logic                      load,
  input  logic [CHANNELS-1:0]       polarity,
  input  logic [CHANNELS-1:0]       enable,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      load_ack,
  output logic                      period_start
);

  // Handshake: load is a single-cycle strobe with no backpressure (always accepted);
  // load_ack and period_start are single-cycle pulses with no ready side.

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [WIDTH-1:0]          shd_period_q, act_period_q;
  logic [CHANNELS*WIDTH-1:0] shd_duty_q, act_duty_q;
  logic                      shd_mode_q, act_mode_q;
  logic                      pending_q, pending_d;

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  dir_e                      dir_q, dir_d;

  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic                      ack_q, ack_d;
  logic                      ps_q, ps_d;

  logic                      stopped;
  logic                      boundary;
  logic [WIDTH-1:0]          last_cnt;

  assign stopped  = (act_period_q == '0);
  assign last_cnt = act_period_q - 1'b1;

  // A zero active period parks the block in a permanent boundary so a pending load
  // is taken on the very next cycle.
  always_comb begin
    boundary = 1'b0;
    if (stopped) begin
      boundary = 1'b1;
    end else if (act_mode_q) begin
      boundary = (dir_q == DIR_DOWN) && (cnt_q == '0);
    end else begin
      boundary = (cnt_q == last_cnt);
    end
  end

  assign pending_d = load | (pending_q & ~boundary);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shd_period_q <= '0;
      shd_duty_q   <= '0;
      shd_mode_q   <= 1'b0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      act_mode_q   <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      if (load) begin
        shd_period_q <= period;
        shd_duty_q   <= duty;
        shd_mode_q   <= mode;
      end
      if (boundary && pending_q) begin
        act_period_q <= shd_period_q;
        act_duty_q   <= shd_duty_q;
        act_mode_q   <= shd_mode_q;
      end
      pending_q <= pending_d;
    end
  end

  // Counter / direction FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // Center mode holds the top value for one extra cycle while turning around.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (boundary) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (!act_mode_q) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == last_cnt) begin
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (enable[i]) begin
        pwm_d[i] = (!stopped && (cnt_q < act_duty_q[i*WIDTH +: WIDTH])) ^ polarity[i];
      end else begin
        pwm_d[i] = polarity[i];
      end
    end
    ack_d = boundary & pending_q;
    ps_d  = boundary & ~stopped;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q <= '0;
      ack_q <= 1'b0;
      ps_q  <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
      ack_q <= ack_d;
      ps_q  <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign load_ack     = ack_q;
  assign period_start = ps_q;

endmodule
